video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Parametrised raster timing generator for the LCD video path; successor to the fixed 800x480 position/sync block.
//  Produces pixel position, draw-valid, blanking and HSYNC/VSYNC/DE for any panel geometry.
//  Adds configurable sync polarity, SOF/SOL pulses, a frame counter and a sync/DE delay line
//  that aligns panel controls with a pixel generator of known pipeline latency.
// PARAMETERS
//  H_ACTIVE   800  visible pixels per line
//  H_FRONT    40   h front porch (clocks)
//  H_SYNC     128  hsync width (clocks)
//  H_BACK     88   h back porch (clocks)
//  V_ACTIVE   480  visible lines per frame
//  V_FRONT    1    v front porch (lines)
//  V_SYNC     3    vsync width (lines)
//  V_BACK     21   v back porch (lines)
//  HSYNC_POL  0    1 = active-high hsync, 0 = active-low
//  VSYNC_POL  0    1 = active-high vsync, 0 = active-low
//  POS_W      11   width of h_pos/v_pos; elaboration error if < clog2(max(H_TOTAL,V_TOTAL))
//  PIX_LATENCY 1   extra cycles of delay on disp_hsync/vsync/de (0..15)
//  FRAME_W    16   frame counter width
// PORTS
//  disp_clk    in   1      pixel clock (from video PLL)
//  rst         in   1      synchronous, active-high reset
//  en          in   1      run enable (tie to PLL lock)
//  h_pos       out  POS_W  current column (0..H_TOTAL-1)
//  v_pos       out  POS_W  current line (0..V_TOTAL-1)
//  valid_draw  out  1      h_pos<H_ACTIVE && v_pos<V_ACTIVE
//  v_blank     out  1      v_pos>=V_ACTIVE
//  sof         out  1      1-cycle pulse at (0,0)
//  sol         out  1      1-cycle pulse at h_pos==0 on each active line
//  frame_cnt   out  FRAME_W completed-frame count, wraps
//  disp_hsync  out  1      hsync, polarity per HSYNC_POL, delayed PIX_LATENCY
//  disp_vsync  out  1      vsync, polarity per VSYNC_POL, delayed PIX_LATENCY
//  disp_de     out  1      data enable = valid_draw delayed PIX_LATENCY
// BEHAVIOUR
//  - H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. Line order: active, front, sync, back.
//  - Internal counters hc/vc. hc increments each enabled cycle and wraps at H_TOTAL-1 -> 0.
//    vc increments on hc wrap and wraps at V_TOTAL-1 -> 0; frame_cnt increments on that wrap.
//  - All outputs registered from hc/vc: 1-cycle latency. First enabled edge after reset shows
//    h_pos=0, v_pos=0, valid_draw=1, sof=1, sol=1.
//  - hsync asserted for hc in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
//    vsync asserted for whole lines vc in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC); edges coincide with hc==0.
//  - disp_* = undelayed hsync/vsync/de through a PIX_LATENCY-stage shift register;
//    PIX_LATENCY=0 is a wire-through of the registered values.
//  - Reset (rst=1) or en=0: counters <=0, frame_cnt<=0 (reset only; held on en=0).
//    h_pos/v_pos<=0; valid_draw/v_blank/sof/sol/disp_de<=0.
//    disp_hsync<=~HSYNC_POL, disp_vsync<=~VSYNC_POL (inactive); delay line flushed to inactive.
//  - en dropped mid-frame: frame aborted, no frame_cnt increment; restart at (0,0) with sof.
//  - rst dominates en. No other inputs; no back-pressure.
// STRUCTURE
//  - video_timing_pkg: default 800x480 geometry constants, H_TOTAL/V_TOTAL functions, polarity localparams.
//  - Sub-module sync_delay_line (WIDTH=3, DEPTH=PIX_LATENCY, RESET_VAL) for the disp_* alignment.
//  - Top: counters, compare decode, output registers.
// TESTING (small config: H 8/2/3/3 =16, V 4/1/2/1 =8, active-low)
//  1. rst held 5 clks, en=1 -> hsync/vsync=1, de=0, pos=0; release -> next edge h_pos=0, v_pos=0, valid_draw=1, sof=1.
//  2. Free-run 3 frames -> period 128 clks; 32 valid_draw per frame; hsync low 3 clks from hc=10; vsync low 32 clks from vc=5.
//  3. PIX_LATENCY=2 -> every disp_de/hsync/vsync edge trails its undelayed edge by exactly 2 clks.
//  4. en=0 at (5,2) for 3 clks -> outputs idle; en=1 -> resume at (0,0) with sof; frame_cnt unchanged.
//  5. FRAME_W=4, run 17 frames -> frame_cnt 15 then 0 then 1.
//  6. rst=1 with en=1 mid-frame -> next edge all outputs reset values; frame_cnt=0.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Default panel geometry and helpers shared by the raster timing generator.
// Geometry defaults describe the 800x480 LCD panel.
package video_timing_pkg;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FRONT  = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BACK   = 88;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 1;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BACK   = 21;

    localparam bit POL_ACTIVE_LOW  = 1'b0;
    localparam bit POL_ACTIVE_HIGH = 1'b1;

    function automatic int calc_h_total(input int active, input int front,
                                        input int sync_w, input int back);
        return active + front + sync_w + back;
    endfunction

    function automatic int calc_v_total(input int active, input int front,
                                        input int sync_w, input int back);
        return active + front + sync_w + back;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that aligns panel control signals with pixel data.
// A clear flushes every stage to the idle value in one cycle.
module sync_delay_line #(
    parameter int             WIDTH     = 3,
    parameter int             DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (clear) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: position, blanking, SOF/SOL, frame count
// and polarity-configurable HSYNC/VSYNC/DE aligned to the pixel pipeline latency.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    parameter bit HSYNC_POL   = POL_ACTIVE_LOW,
    parameter bit VSYNC_POL   = POL_ACTIVE_LOW,
    parameter int POS_W       = 11,
    parameter int PIX_LATENCY = 1,
    parameter int FRAME_W     = 16
) (
    input  logic               disp_clk,
    input  logic               rst,
    input  logic               en,
    output logic [POS_W-1:0]   h_pos,
    output logic [POS_W-1:0]   v_pos,
    output logic               valid_draw,
    output logic               v_blank,
    output logic               sof,
    output logic               sol,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               disp_hsync,
    output logic               disp_vsync,
    output logic               disp_de
);

    localparam int H_TOTAL = calc_h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = calc_v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

    generate
        if (POS_W < $clog2(max2(H_TOTAL, V_TOTAL))) begin : g_pos_w_check
            $error("POS_W too narrow for the configured raster");
        end
        if (PIX_LATENCY < 0 || PIX_LATENCY > 15) begin : g_latency_check
            $error("PIX_LATENCY must be in 0..15");
        end
    endgenerate

    localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] H_ACT    = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] V_ACT    = POS_W'(V_ACTIVE);
    localparam logic [POS_W-1:0] HS_START = POS_W'(H_ACTIVE + H_FRONT);
    localparam logic [POS_W-1:0] HS_END   = POS_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [POS_W-1:0] VS_START = POS_W'(V_ACTIVE + V_FRONT);
    localparam logic [POS_W-1:0] VS_END   = POS_W'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic HS_IDLE = ~HSYNC_POL;
    localparam logic VS_IDLE = ~VSYNC_POL;

    logic             run;
    logic [POS_W-1:0] hc_p0;
    logic [POS_W-1:0] vc_p0;
    logic             h_wrap_p0;
    logic             v_wrap_p0;
    logic             h_act_p0;
    logic             v_act_p0;
    logic             hsync_p0;
    logic             vsync_p0;
    logic             hsync_p1;
    logic             vsync_p1;
    logic             de_p1;

    assign run = en && !rst;

    // Stage p0: raster counters; an idle or reset cycle restarts the frame at (0,0).
    always_ff @(posedge disp_clk) begin
        if (!run) begin
            hc_p0 <= '0;
            vc_p0 <= '0;
        end else if (h_wrap_p0) begin
            hc_p0 <= '0;
            vc_p0 <= v_wrap_p0 ? '0 : vc_p0 + POS_W'(1);
        end else begin
            hc_p0 <= hc_p0 + POS_W'(1);
        end
    end

    // Only frames that reach the last pixel are counted; aborted frames are not.
    always_ff @(posedge disp_clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (en && h_wrap_p0 && v_wrap_p0) begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
        end
    end

    always_comb begin
        h_wrap_p0 = (hc_p0 == H_LAST);
        v_wrap_p0 = (vc_p0 == V_LAST);
        h_act_p0  = (hc_p0 < H_ACT);
        v_act_p0  = (vc_p0 < V_ACT);
        hsync_p0  = ((hc_p0 >= HS_START) && (hc_p0 < HS_END)) ? HSYNC_POL : HS_IDLE;
        vsync_p0  = ((vc_p0 >= VS_START) && (vc_p0 < VS_END)) ? VSYNC_POL : VS_IDLE;
    end

    // Stage p1: registered position, flags and undelayed panel controls.
    always_ff @(posedge disp_clk) begin
        if (!run) begin
            h_pos      <= '0;
            v_pos      <= '0;
            valid_draw <= 1'b0;
            v_blank    <= 1'b0;
            sof        <= 1'b0;
            sol        <= 1'b0;
            hsync_p1   <= HS_IDLE;
            vsync_p1   <= VS_IDLE;
            de_p1      <= 1'b0;
        end else begin
            h_pos      <= hc_p0;
            v_pos      <= vc_p0;
            valid_draw <= h_act_p0 && v_act_p0;
            v_blank    <= !v_act_p0;
            sof        <= (hc_p0 == '0) && (vc_p0 == '0);
            sol        <= (hc_p0 == '0) && v_act_p0;
            hsync_p1   <= hsync_p0;
            vsync_p1   <= vsync_p0;
            de_p1      <= h_act_p0 && v_act_p0;
        end
    end

    // Stage p2..: align panel controls with the downstream pixel generator.
    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (PIX_LATENCY),
        .RESET_VAL ({HS_IDLE, VS_IDLE, 1'b0})
    ) u_sync_delay (
        .clk   (disp_clk),
        .clear (!run),
        .din   ({hsync_p1, vsync_p1, de_p1}),
        .dout  ({disp_hsync, disp_vsync, disp_de})
    );

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 16x8 raster, active-low syncs, 2-cycle sync delay.
// A behavioural raster model pushes expectations per cycle; the DUT outputs are popped and compared.
module tb_video_timing_gen;

    localparam int POS_W   = 5;
    localparam int FRAME_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en  = 1'b1;
    logic [POS_W-1:0]   h_pos;
    logic [POS_W-1:0]   v_pos;
    logic               valid_draw;
    logic               v_blank;
    logic               sof;
    logic               sol;
    logic [FRAME_W-1:0] frame_cnt;
    logic               disp_hsync;
    logic               disp_vsync;
    logic               disp_de;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .POS_W(POS_W), .PIX_LATENCY(2), .FRAME_W(FRAME_W)
    ) dut (
        .disp_clk   (clk),
        .rst        (rst),
        .en         (en),
        .h_pos      (h_pos),
        .v_pos      (v_pos),
        .valid_draw (valid_draw),
        .v_blank    (v_blank),
        .sof        (sof),
        .sol        (sol),
        .frame_cnt  (frame_cnt),
        .disp_hsync (disp_hsync),
        .disp_vsync (disp_vsync),
        .disp_de    (disp_de)
    );

    typedef struct packed {
        logic [POS_W-1:0]   h;
        logic [POS_W-1:0]   v;
        logic               vd;
        logic               vb;
        logic               sof;
        logic               sol;
        logic [FRAME_W-1:0] fc;
        logic [2:0]         disp;
    } expect_t;

    expect_t sb[$];

    int n_total = 0;
    int n_pass  = 0;

    int               mh = 0;
    int               mv = 0;
    logic [FRAME_W-1:0] mframe = '0;
    logic [2:0]       m_r  = 3'b110;
    logic [2:0]       m_s0 = 3'b110;
    logic [2:0]       m_s1 = 3'b110;

    int cyc = 0;
    int n_vd = 0;
    int n_hs = 0;
    int n_vs = 0;
    int n_sof = 0;
    int last_sof = -1;
    int sof_period = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_vd = 0;
        n_hs = 0;
        n_vs = 0;
        n_sof = 0;
        last_sof = -1;
        sof_period = 0;
    endtask

    task automatic step();
        expect_t e;
        logic hact;
        logic vact;
        logic [2:0] und;
        e = '0;
        if (rst || !en) begin
            if (rst) mframe = '0;
            m_r  = 3'b110;
            m_s0 = 3'b110;
            m_s1 = 3'b110;
            mh = 0;
            mv = 0;
        end else begin
            hact  = (mh < 8);
            vact  = (mv < 4);
            e.h   = POS_W'(mh);
            e.v   = POS_W'(mv);
            e.vd  = hact && vact;
            e.vb  = !vact;
            e.sof = (mh == 0) && (mv == 0);
            e.sol = (mh == 0) && vact;
            und   = {!(mh >= 10 && mh < 13), !(mv >= 5 && mv < 7), hact && vact};
            if (mh == 15 && mv == 7) mframe = mframe + 1'b1;
            m_s1 = m_s0;
            m_s0 = m_r;
            m_r  = und;
            if (mh == 15) begin
                mh = 0;
                mv = (mv == 7) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
        e.fc   = mframe;
        e.disp = m_s1;
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("pos",       32'({h_pos, v_pos}), 32'({e.h, e.v}));
        check("flags",     32'({valid_draw, v_blank, sof, sol}), 32'({e.vd, e.vb, e.sof, e.sol}));
        check("frame_cnt", 32'(frame_cnt), 32'(e.fc));
        check("disp",      32'({disp_hsync, disp_vsync, disp_de}), 32'(e.disp));

        if (valid_draw) n_vd++;
        if (!disp_hsync) n_hs++;
        if (!disp_vsync) n_vs++;
        if (sof) begin
            if (last_sof >= 0) sof_period = cyc - last_sof;
            last_sof = cyc;
            n_sof++;
        end
        cyc++;
    endtask

    initial begin
        // reset held with en high
        rst = 1'b1;
        en  = 1'b1;
        repeat (5) step();
        check("rst_hsync", 32'(disp_hsync), 32'd1);
        check("rst_vsync", 32'(disp_vsync), 32'd1);
        check("rst_de",    32'(disp_de), 32'd0);
        check("rst_pos",   32'({h_pos, v_pos}), 32'd0);

        // release: first enabled edge shows (0,0) with sof/sol, then free-run 3 frames
        rst = 1'b0;
        clear_stats();
        step();
        check("first_pos",  32'({h_pos, v_pos}), 32'd0);
        check("first_vd",   32'(valid_draw), 32'd1);
        check("first_sof",  32'(sof), 32'd1);
        check("first_sol",  32'(sol), 32'd1);
        repeat (383) step();
        check("vd_per_3frames",    32'(n_vd), 32'd96);
        check("sof_per_3frames",   32'(n_sof), 32'd3);
        check("sof_period",        32'(sof_period), 32'd128);
        check("hsync_low_3frames", 32'(n_hs), 32'd72);
        check("vsync_low_3frames", 32'(n_vs), 32'd96);

        // drop en at (5,2) for 3 cycles, then resume
        repeat (37) step();
        en = 1'b0;
        repeat (3) step();
        check("idle_vd",    32'(valid_draw), 32'd0);
        check("idle_hsync", 32'(disp_hsync), 32'd1);
        check("idle_de",    32'(disp_de), 32'd0);
        en = 1'b1;
        step();
        check("resume_sof", 32'(sof), 32'd1);
        check("resume_pos", 32'({h_pos, v_pos}), 32'd0);
        check("hold_frame", 32'(frame_cnt), 32'd3);

        // reset mid-frame while enabled
        repeat (20) step();
        rst = 1'b1;
        step();
        check("midrst_fc",    32'(frame_cnt), 32'd0);
        check("midrst_vd",    32'(valid_draw), 32'd0);
        check("midrst_sof",   32'(sof), 32'd0);
        check("midrst_syncs", 32'({disp_hsync, disp_vsync, disp_de}), 32'b110);
        rst = 1'b0;

        // 4-bit frame counter wraps after 16 frames
        repeat (15 * 128) step();
        check("fc_15", 32'(frame_cnt), 32'd15);
        repeat (128) step();
        check("fc_wrap_0", 32'(frame_cnt), 32'd0);
        repeat (128) step();
        check("fc_wrap_1", 32'(frame_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
